// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel-timing generator for the 640x480 @ 60 Hz display path.
// Free-running horizontal/vertical counters drive DrawX/DrawY, the visible-area
// flag and line/frame strobes. hs/vs are delayed SYNC_DLY clocks so they line up
// with the registered RGB from the drawing stages.
// Optional feature: define VGA_SYNC_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned SYNC_DLY  = 1
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        end_of_line,
`ifdef VGA_SYNC_FRAME_CNT_EN
    output logic        end_of_frame,
    output logic [15:0] frame_cnt
`else
    output logic        end_of_frame
`endif
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Both totals must fit the 10-bit counters (<= 1024).
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       hs_raw, vs_raw;

    // Next-state for the counters: hc always advances, vc only on a line wrap.
    always_comb begin
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    // Coordinate, visible-area, strobe and raw sync decodes of the counters.
    always_comb begin
        DrawX        = hc_q;
        DrawY        = vc_q;
        blank        = (hc_q < H_VIS) && (vc_q < V_VIS);
        end_of_line  = (hc_q == H_LAST);
        end_of_frame = (hc_q == H_LAST) && (vc_q == V_LAST);
        hs_raw       = !((hc_q >= HS_FIRST) && (hc_q <= HS_LAST));
        vs_raw       = !((vc_q >= VS_FIRST) && (vc_q <= VS_LAST));
    end

    generate
        if (SYNC_DLY == 0) begin : g_sync_comb
            assign hs = hs_raw;
            assign vs = vs_raw;
        end else if (SYNC_DLY == 1) begin : g_sync_one
            logic hs_pipe_q, vs_pipe_q;

            // Single sync delay stage; reset flushes to inactive (high).
            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    hs_pipe_q <= 1'b1;
                    vs_pipe_q <= 1'b1;
                end else begin
                    hs_pipe_q <= hs_raw;
                    vs_pipe_q <= vs_raw;
                end
            end

            assign hs = hs_pipe_q;
            assign vs = vs_pipe_q;
        end else begin : g_sync_multi
            logic [SYNC_DLY-1:0] hs_pipe_q, vs_pipe_q;

            // Multi-stage sync delay line; reset flushes every stage to inactive.
            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    hs_pipe_q <= '1;
                    vs_pipe_q <= '1;
                end else begin
                    hs_pipe_q <= {hs_pipe_q[SYNC_DLY-2:0], hs_raw};
                    vs_pipe_q <= {vs_pipe_q[SYNC_DLY-2:0], vs_raw};
                end
            end

            assign hs = hs_pipe_q[SYNC_DLY-1];
            assign vs = vs_pipe_q[SYNC_DLY-1];
        end
    endgenerate

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Completed-frame counter, wraps naturally at 16 bits.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
        end else if (end_of_frame) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance (SYNC_DLY=1) and a
// small-timing instance (SYNC_DLY=2) so whole frames fit in a short run.
// Expected outputs come from an arithmetic model of elapsed clocks since reset.
module tb_vga_sync_gen;

    // Small instance timing: H total 24, V total 15, frame 360 clocks.
    localparam int unsigned S_HV = 16, S_HFP = 2, S_HSY = 4, S_HBP = 2;
    localparam int unsigned S_VV = 8, S_VFP = 2, S_VSY = 2, S_VBP = 3;
    localparam int unsigned S_DLY = 2;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        blank;
        logic        hs;
        logic        vs;
        logic        eol;
        logic        eof;
        logic [15:0] fc;
    } exp_t;

    typedef struct {
        int unsigned t;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        blank;
        logic        hs;
        logic        eol;
    } vec_t;

    logic clk = 1'b0;
    logic rst_d_n = 1'b0;
    logic rst_s_n = 1'b0;

    logic [9:0]  x_d, y_d, x_s, y_s;
    logic        blank_d, hs_d, vs_d, eol_d, eof_d;
    logic        blank_s, hs_s, vs_s, eol_s, eof_s;
    logic [15:0] fc_d, fc_s;

    int unsigned t_d = 0;
    int unsigned t_s = 0;
    logic [15:0] fc_off_s = 16'h0000;
    logic        mon_on = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    vga_sync_gen dut_d (
        .vga_clk      (clk),
        .reset_n      (rst_d_n),
        .DrawX        (x_d),
        .DrawY        (y_d),
        .blank        (blank_d),
        .hs           (hs_d),
        .vs           (vs_d),
        .end_of_line  (eol_d),
`ifdef VGA_SYNC_FRAME_CNT_EN
        .end_of_frame (eof_d),
        .frame_cnt    (fc_d)
`else
        .end_of_frame (eof_d)
`endif
    );

    vga_sync_gen #(
        .H_VISIBLE (S_HV),
        .H_FP      (S_HFP),
        .H_SYNC    (S_HSY),
        .H_BP      (S_HBP),
        .V_VISIBLE (S_VV),
        .V_FP      (S_VFP),
        .V_SYNC    (S_VSY),
        .V_BP      (S_VBP),
        .SYNC_DLY  (S_DLY)
    ) dut_s (
        .vga_clk      (clk),
        .reset_n      (rst_s_n),
        .DrawX        (x_s),
        .DrawY        (y_s),
        .blank        (blank_s),
        .hs           (hs_s),
        .vs           (vs_s),
        .end_of_line  (eol_s),
`ifdef VGA_SYNC_FRAME_CNT_EN
        .end_of_frame (eof_s),
        .frame_cnt    (fc_s)
`else
        .end_of_frame (eof_s)
`endif
    );

`ifndef VGA_SYNC_FRAME_CNT_EN
    assign fc_d = 16'h0000;
    assign fc_s = 16'h0000;
`endif

    // Elapsed clock edges since each reset release (the model's time base).
    always @(posedge clk or negedge rst_d_n) begin
        if (!rst_d_n) t_d <= 0;
        else          t_d <= t_d + 1;
    end

    always @(posedge clk or negedge rst_s_n) begin
        if (!rst_s_n) t_s <= 0;
        else          t_s <= t_s + 1;
    end

    // Position after t clocks, sync from the position d clocks earlier.
    function automatic exp_t model(input int unsigned t, input int unsigned hv, hfp, hsy,
                                   hbp, vv, vfp, vsy, vbp, d, input logic [15:0] fc_off);
        int unsigned ht = hv + hfp + hsy + hbp;
        int unsigned vt = vv + vfp + vsy + vbp;
        int unsigned x = t % ht;
        int unsigned y = (t / ht) % vt;
        int unsigned xr, yr;
        exp_t e;
        e.x     = 10'(x);
        e.y     = 10'(y);
        e.blank = (x < hv) && (y < vv);
        e.eol   = (x == ht - 1);
        e.eof   = (x == ht - 1) && (y == vt - 1);
        if (t < d) begin
            e.hs = 1'b1;
            e.vs = 1'b1;
        end else begin
            xr   = (t - d) % ht;
            yr   = ((t - d) / ht) % vt;
            e.hs = !((xr >= hv + hfp) && (xr < hv + hfp + hsy));
            e.vs = !((yr >= vv + vfp) && (yr < vv + vfp + vsy));
        end
        e.fc = fc_off + 16'(t / (ht * vt));
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors < 40) $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req,
                                      $time);
        end
    endtask

    task automatic cmp_inst(input string tag, input exp_t e, input exp_t a);
        check({tag, ".DrawX"}, 32'(a.x), 32'(e.x));
        check({tag, ".DrawY"}, 32'(a.y), 32'(e.y));
        check({tag, ".blank"}, 32'(a.blank), 32'(e.blank));
        check({tag, ".hs"}, 32'(a.hs), 32'(e.hs));
        check({tag, ".vs"}, 32'(a.vs), 32'(e.vs));
        check({tag, ".end_of_line"}, 32'(a.eol), 32'(e.eol));
        check({tag, ".end_of_frame"}, 32'(a.eof), 32'(e.eof));
`ifdef VGA_SYNC_FRAME_CNT_EN
        check({tag, ".frame_cnt"}, 32'(a.fc), 32'(e.fc));
`endif
    endtask

    // Continuous scoreboard: both instances against the model on every falling edge.
    always @(negedge clk) begin
        if (mon_on) begin
            cmp_inst("mon_d", model(t_d, 640, 16, 96, 48, 480, 10, 2, 33, 1, 16'h0000),
                     {x_d, y_d, blank_d, hs_d, vs_d, eol_d, eof_d, fc_d});
            cmp_inst("mon_s", model(t_s, S_HV, S_HFP, S_HSY, S_HBP, S_VV, S_VFP, S_VSY, S_VBP,
                                    S_DLY, fc_off_s),
                     {x_s, y_s, blank_s, hs_s, vs_s, eol_s, eof_s, fc_s});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_vals(input string tag);
        check({tag, ".DrawX"}, 32'(x_s), 32'd0);
        check({tag, ".DrawY"}, 32'(y_s), 32'd0);
        check({tag, ".hs"}, 32'(hs_s), 32'd1);
        check({tag, ".vs"}, 32'(vs_s), 32'd1);
        check({tag, ".blank"}, 32'(blank_s), 32'd1);
        check({tag, ".eol"}, 32'(eol_s), 32'd0);
        check({tag, ".eof"}, 32'(eof_s), 32'd0);
`ifdef VGA_SYNC_FRAME_CNT_EN
        check({tag, ".frame_cnt"}, 32'(fc_s), 32'd0);
`endif
    endtask

    initial begin
        vec_t vec[13];
        int   n;
        int   bound;
        logic early_low;

        vec[0]  = '{1,    10'd1,   10'd0, 1'b1, 1'b1, 1'b0};
        vec[1]  = '{2,    10'd2,   10'd0, 1'b1, 1'b1, 1'b0};
        vec[2]  = '{3,    10'd3,   10'd0, 1'b1, 1'b1, 1'b0};
        vec[3]  = '{639,  10'd639, 10'd0, 1'b1, 1'b1, 1'b0};
        vec[4]  = '{640,  10'd640, 10'd0, 1'b0, 1'b1, 1'b0};
        vec[5]  = '{656,  10'd656, 10'd0, 1'b0, 1'b1, 1'b0};
        vec[6]  = '{657,  10'd657, 10'd0, 1'b0, 1'b0, 1'b0};
        vec[7]  = '{752,  10'd752, 10'd0, 1'b0, 1'b0, 1'b0};
        vec[8]  = '{753,  10'd753, 10'd0, 1'b0, 1'b1, 1'b0};
        vec[9]  = '{799,  10'd799, 10'd0, 1'b0, 1'b1, 1'b1};
        vec[10] = '{800,  10'd0,   10'd1, 1'b1, 1'b1, 1'b0};
        vec[11] = '{1599, 10'd799, 10'd1, 1'b0, 1'b1, 1'b1};
        vec[12] = '{1600, 10'd0,   10'd2, 1'b1, 1'b1, 1'b0};

        // Reset held across several edges.
        repeat (3) @(negedge clk);
        check("rst.DrawX", 32'(x_d), 32'd0);
        check("rst.DrawY", 32'(y_d), 32'd0);
        check("rst.hs", 32'(hs_d), 32'd1);
        check("rst.vs", 32'(vs_d), 32'd1);
        check("rst.blank", 32'(blank_d), 32'd1);
        check("rst.eof", 32'(eof_d), 32'd0);
        check_reset_vals("rst_s");
        mon_on = 1'b1;
        @(posedge clk);
        #2;
        rst_d_n = 1'b1;
        rst_s_n = 1'b1;

        // Table of horizontal boundary points on the default instance.
        for (int i = 0; i < 13; i++) begin
            bound = 0;
            while (t_d < vec[i].t && bound < 5000) begin
                @(negedge clk);
                bound++;
            end
            if (t_d != vec[i].t) begin
                checks++;
                errors++;
                $display("FAIL vec%0d_reach actual=%0d required=%0d", i, t_d, vec[i].t);
            end
            check($sformatf("vec%0d.DrawX", i), 32'(x_d), 32'(vec[i].x));
            check($sformatf("vec%0d.DrawY", i), 32'(y_d), 32'(vec[i].y));
            check($sformatf("vec%0d.blank", i), 32'(blank_d), 32'(vec[i].blank));
            check($sformatf("vec%0d.hs", i), 32'(hs_d), 32'(vec[i].hs));
            check($sformatf("vec%0d.eol", i), 32'(eol_d), 32'(vec[i].eol));
        end

        // Line period on the default instance.
        bound = 0;
        while (!eol_d && bound < 2000) begin @(negedge clk); bound++; end
        n = 0;
        @(negedge clk);
        while (!eol_d && n < 2000) begin @(negedge clk); n++; end
        check("line_period", 32'(n + 1), 32'd800);

        // Frame period on the small instance.
        bound = 0;
        while (!eof_s && bound < 1000) begin @(negedge clk); bound++; end
        n = 0;
        @(negedge clk);
        while (!eof_s && n < 1000) begin @(negedge clk); n++; end
        check("frame_period", 32'(n + 1), 32'd360);
        @(negedge clk);
        check("frame_wrap.xy", {x_s, y_s}, 32'd0);
        check("frame_wrap.blank", 32'(blank_s), 32'd1);

        // Mid-frame reset while both syncs are low.
        bound = 0;
        while (!(x_s == 10'd21 && y_s == 10'd10) && bound < 1000) begin
            @(negedge clk);
            bound++;
        end
        check("midrst.pre_hs", 32'(hs_s), 32'd0);
        check("midrst.pre_vs", 32'(vs_s), 32'd0);
        #1;
        rst_s_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(posedge clk);
        #2;
        rst_s_n = 1'b1;
        early_low = 1'b0;
        bound = 0;
        @(negedge clk);
        while (x_s != 10'd20 && bound < 100) begin
            if (!hs_s || !vs_s) early_low = 1'b1;
            @(negedge clk);
            bound++;
        end
        check("midrst.no_partial_pulse", 32'(early_low), 32'd0);
        check("midrst.hs_starts", 32'(hs_s), 32'd0);

        // Asynchronous resets at random points, then the first count steps.
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(1, 700)) @(negedge clk);
            @(posedge clk);
            #2;
            rst_s_n = 1'b0;
            #1;
            check_reset_vals($sformatf("rnd%0d", k));
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #2;
            rst_s_n = 1'b1;
            for (int s = 1; s <= 3; s++) begin
                @(posedge clk);
                #1;
                check($sformatf("rnd%0d.count%0d", k, s), 32'(x_s), 32'(s));
            end
        end

`ifdef VGA_SYNC_FRAME_CNT_EN
        // Preload frame_cnt just below wrap; the next frame end must roll it over.
        @(negedge clk);
        #1;
        force dut_s.frame_cnt_q = 16'hFFFF;
        #1;
        release dut_s.frame_cnt_q;
        fc_off_s = 16'hFFFF - 16'(t_s / 360);
        check("fc.preload", 32'(fc_s), 32'hFFFF);
        bound = 0;
        @(negedge clk);
        while (!eof_s && bound < 1000) begin @(negedge clk); bound++; end
        check("fc.before_wrap", 32'(fc_s), 32'hFFFF);
        @(negedge clk);
        check("fc.wrap", 32'(fc_s), 32'h0000);
        bound = 0;
        while (!eof_s && bound < 1000) begin @(negedge clk); bound++; end
        @(negedge clk);
        check("fc.after_wrap", 32'(fc_s), 32'h0001);
`endif

        repeat (50) @(negedge clk);
        mon_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Pixel-timing generator for the 640x480 @ 60 Hz display path. It runs on the pixel clock and produces the DrawX/DrawY coordinates and the active-high visible-area flag `blank` consumed by the sprite/palette drawing stages. It also produces the hsync/vsync pins, delayed so they stay aligned with the one-cycle-registered RGB those stages output. It also provides line/frame boundary strobes for game logic.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_DLY, 1, register stages on hs/vs (0..3), matching the downstream RGB latency

Ports:
- Clock and reset: one clock, `vga_clk`; asynchronous active-low reset, `reset_n`.
- vga_clk  input  1  pixel clock
- reset_n  input  1  async active-low reset
- DrawX  output  10  current horizontal count (0..H_TOTAL-1)
- DrawY  output  10  current vertical count (0..V_TOTAL-1)
- blank  output  1  1 = (DrawX, DrawY) inside visible area
- hs  output  1  horizontal sync, active low, delayed SYNC_DLY clocks
- vs  output  1  vertical sync, active low, delayed SYNC_DLY clocks
- end_of_line  output  1  1 when DrawX == H_TOTAL-1
- end_of_frame  output  1  1 when DrawX == H_TOTAL-1 and DrawY == V_TOTAL-1
- frame_cnt  output  16  frames completed (present only with VGA_SYNC_FRAME_CNT_EN)

## Operation
- Totals:
  - H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (default 800).
  - V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (default 525).
  - Both totals must be ≤ 1024.
- Horizontal counter `hc`:
  - Increments every clock.
  - At H_TOTAL-1 it wraps to 0.
- Vertical counter `vc`:
  - Advances only on a horizontal wrap.
  - At V_TOTAL-1 with hc == H_TOTAL-1, it wraps to 0.
- DrawX = hc and DrawY = vc, driven straight from the counter registers.
- blank = (hc < H_VISIBLE) && (vc < V_VISIBLE). Combinational decode of the counter registers.
- Sync decode:
  - hs_raw = 0 for hc in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] (default 656..751).
  - vs_raw = 0 for vc in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1] (default 490..491), over whole lines.
  - hs/vs = hs_raw/vs_raw passed through SYNC_DLY flops. SYNC_DLY = 0 gives a combinational pass-through.
- end_of_line and end_of_frame are combinational decodes, each high for exactly one clock.
- No state machine beyond the counters. Counter arithmetic is unsigned 10-bit; compare against parameter-derived constants.

## Timing
- Reset (reset_n low, asynchronous):
  - hc = vc = 0, so DrawX = 0 and DrawY = 0.
  - All hs/vs delay flops = 1, so hs = vs = 1.
  - blank = 1, because (0,0) is visible.
  - end_of_line = end_of_frame = 0.
  - frame_cnt = 0.
- First rising edge after reset_n deasserts: DrawX = 1.
- Line period is 800 clocks; frame period is 420000 clocks.
- hs timing:
  - With SYNC_DLY = 1, hs is low on the cycles where DrawX = 657..752.
  - This is 96 clocks, lagging the decode by 1 cycle, aligned with registered RGB.
- Line wrap: DrawX 799 → 0 and DrawY +1 on the same edge.
- Frame wrap: DrawX/DrawY go from (799, 524) to (0, 0) on one edge.
- Reset asserted mid-frame: all outputs return to their reset values immediately. The sync delay line is flushed to inactive, with no partial pulse held over.

## Configuration
- Macro `VGA_SYNC_FRAME_CNT_EN`.
- Defined:
  - The 16-bit `frame_cnt` port exists.
  - It increments on the clock edge where end_of_frame = 1.
  - It wraps 0xFFFF → 0x0000; reset value is 0.
- Undefined: the port and its register are absent. All other behaviour is identical.

## Test plan
- Reset: hold reset_n low mid-count. Required: DrawX=0, DrawY=0, hs=1, vs=1, blank=1, end_of_frame=0 asynchronously. After release, DrawX counts 1, 2, 3 on successive edges.
- Horizontal timing, SYNC_DLY=1: hs low exactly 96 clocks, for DrawX 657..752. blank falls when DrawX=640 (DrawY<480). end_of_line pulses once at DrawX=799, then DrawX=0 and DrawY increments.
- Vertical timing: vs low for whole lines 490..491 (1600 clocks, shifted 1 clock). blank = 0 for DrawY 480..524.
- Frame wrap: at (799, 524), end_of_frame = 1 for one clock. The next edge gives (0, 0) and blank = 1. Frame period measures 420000 clocks.
- Mid-frame reset at DrawX=700, DrawY=490 (hs and vs low). Required: hs=vs=1 immediately; no low pulse on hs/vs until DrawX reaches 657 in the new frame.
- With VGA_SYNC_FRAME_CNT_EN, and frame_cnt forced or preloaded near wrap: it increments once per end_of_frame, and 0xFFFF → 0x0000 on the next frame. Without the macro, the bench compiles without the port.
